// File: rtl/io_write_arbiter_if.sv
// Shared write-port bundle between the two requesters and the output-port write path.
interface io_write_arbiter_if;
  logic        a_valid;
  logic        a_lock;
  logic [31:0] a_addr;
  logic [31:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic        b_lock;
  logic [31:0] b_addr;
  logic [31:0] b_data;
  logic        b_ready;
  logic        write_io_enable;
  logic [31:0] io_addr;
  logic [31:0] io_datain;
  logic        grant_b;
  logic        addr_err;

  modport master (
    output a_valid, a_lock, a_addr, a_data,
    output b_valid, b_lock, b_addr, b_data,
    input  a_ready, b_ready,
    input  write_io_enable, io_addr, io_datain, grant_b, addr_err
  );

  modport slave (
    input  a_valid, a_lock, a_addr, a_data,
    input  b_valid, b_lock, b_addr, b_data,
    output a_ready, b_ready,
    output write_io_enable, io_addr, io_datain, grant_b, addr_err
  );
endinterface

// File: rtl/io_write_arbiter.sv
// Round-robin arbiter with burst lock for the output-port write path (requesters A and B).
// Optional write/stall statistics ports are enabled by defining IO_ARB_STATS_EN.
module io_write_arbiter #(
  parameter int unsigned MAX_BURST = 4,
  parameter logic [5:0]  PORT_BASE = 6'b100000
) (
  input  logic       io_clk,
  input  logic       resetn,
  io_write_arbiter_if.slave bus
`ifdef IO_ARB_STATS_EN
  ,
  output logic [15:0] wr_cnt_a,
  output logic [15:0] wr_cnt_b,
  output logic [7:0]  stall_max
`endif
);

  typedef enum logic [1:0] {IDLE, LOCK_A, LOCK_B} state_e;

  localparam logic [3:0] MAX_B   = 4'(MAX_BURST);
  localparam bit         LOCK_OK = (MAX_BURST > 1);

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  function automatic logic in_window(input logic [5:0] word_sel);
    logic [6:0] w;
    w = {1'b0, word_sel};
    return (w >= {1'b0, PORT_BASE}) && (w <= ({1'b0, PORT_BASE} + 7'd2));
  endfunction

  state_e      state_q, state_d;
  logic        rr_last_b_q, rr_last_b_d;
  logic [3:0]  burst_cnt_q, burst_cnt_d;
  logic        we_q, we_d;
  logic [31:0] io_addr_q, io_addr_d;
  logic [31:0] io_datain_q, io_datain_d;
  logic        grant_b_q, grant_b_d;
  logic        addr_err_q, addr_err_d;

  logic        gnt_a, gnt_b, idle_eval, legal;
  logic [31:0] sel_addr, sel_data;

  always_comb begin
    gnt_a       = 1'b0;
    gnt_b       = 1'b0;
    idle_eval   = 1'b0;
    state_d     = state_q;
    rr_last_b_d = rr_last_b_q;
    burst_cnt_d = burst_cnt_q;

    case (state_q)
      LOCK_A: begin
        if (bus.a_valid && bus.a_lock) begin
          gnt_a       = 1'b1;
          burst_cnt_d = sat_inc4(burst_cnt_q);
          if (burst_cnt_d >= MAX_B) begin
            state_d     = IDLE;
            rr_last_b_d = 1'b0;
            burst_cnt_d = 4'd0;
          end
        end else begin
          idle_eval = 1'b1;
        end
      end
      LOCK_B: begin
        if (bus.b_valid && bus.b_lock) begin
          gnt_b       = 1'b1;
          burst_cnt_d = sat_inc4(burst_cnt_q);
          if (burst_cnt_d >= MAX_B) begin
            state_d     = IDLE;
            rr_last_b_d = 1'b1;
            burst_cnt_d = 4'd0;
          end
        end else begin
          idle_eval = 1'b1;
        end
      end
      default: idle_eval = 1'b1;
    endcase

    // A lock holder that lets go is treated exactly like IDLE in the same cycle.
    if (idle_eval) begin
      state_d     = IDLE;
      burst_cnt_d = 4'd0;
      if (bus.a_valid && (!bus.b_valid || rr_last_b_q)) begin
        gnt_a = 1'b1;
      end else if (bus.b_valid) begin
        gnt_b = 1'b1;
      end
      if (gnt_a) begin
        rr_last_b_d = 1'b0;
        if (bus.a_lock && LOCK_OK) begin
          state_d     = LOCK_A;
          burst_cnt_d = 4'd1;
        end
      end
      if (gnt_b) begin
        rr_last_b_d = 1'b1;
        if (bus.b_lock && LOCK_OK) begin
          state_d     = LOCK_B;
          burst_cnt_d = 4'd1;
        end
      end
    end
  end

  always_comb begin
    sel_addr    = gnt_b ? bus.b_addr : bus.a_addr;
    sel_data    = gnt_b ? bus.b_data : bus.a_data;
    legal       = in_window(sel_addr[7:2]);
    we_d        = 1'b0;
    addr_err_d  = 1'b0;
    io_addr_d   = io_addr_q;
    io_datain_d = io_datain_q;
    grant_b_d   = grant_b_q;
    if (gnt_a || gnt_b) begin
      we_d        = legal;
      addr_err_d  = !legal;
      io_addr_d   = sel_addr;
      io_datain_d = sel_data;
      grant_b_d   = gnt_b;
    end
  end

  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      rr_last_b_q <= 1'b1;
      burst_cnt_q <= 4'd0;
      we_q        <= 1'b0;
      io_addr_q   <= 32'd0;
      io_datain_q <= 32'd0;
      grant_b_q   <= 1'b0;
      addr_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_last_b_q <= rr_last_b_d;
      burst_cnt_q <= burst_cnt_d;
      we_q        <= we_d;
      io_addr_q   <= io_addr_d;
      io_datain_q <= io_datain_d;
      grant_b_q   <= grant_b_d;
      addr_err_q  <= addr_err_d;
    end
  end

  // Ready is combinational but forced low while reset is asserted.
  assign bus.a_ready         = gnt_a && resetn;
  assign bus.b_ready         = gnt_b && resetn;
  assign bus.write_io_enable = we_q;
  assign bus.io_addr         = io_addr_q;
  assign bus.io_datain       = io_datain_q;
  assign bus.grant_b         = grant_b_q;
  assign bus.addr_err        = addr_err_q;

`ifdef IO_ARB_STATS_EN
  logic [15:0] wr_cnt_a_q, wr_cnt_a_d;
  logic [15:0] wr_cnt_b_q, wr_cnt_b_d;
  logic [7:0]  run_a_q, run_a_d;
  logic [7:0]  run_b_q, run_b_d;
  logic [7:0]  stall_max_q, stall_max_d;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    wr_cnt_a_d  = wr_cnt_a_q;
    wr_cnt_b_d  = wr_cnt_b_q;
    if (bus.a_ready && legal) wr_cnt_a_d = wr_cnt_a_q + 16'd1;
    if (bus.b_ready && legal) wr_cnt_b_d = wr_cnt_b_q + 16'd1;
    run_a_d     = (bus.a_valid && !bus.a_ready) ? sat_inc8(run_a_q) : 8'd0;
    run_b_d     = (bus.b_valid && !bus.b_ready) ? sat_inc8(run_b_q) : 8'd0;
    stall_max_d = stall_max_q;
    if (run_a_d > stall_max_d) stall_max_d = run_a_d;
    if (run_b_d > stall_max_d) stall_max_d = run_b_d;
  end

  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      wr_cnt_a_q  <= 16'd0;
      wr_cnt_b_q  <= 16'd0;
      run_a_q     <= 8'd0;
      run_b_q     <= 8'd0;
      stall_max_q <= 8'd0;
    end else begin
      wr_cnt_a_q  <= wr_cnt_a_d;
      wr_cnt_b_q  <= wr_cnt_b_d;
      run_a_q     <= run_a_d;
      run_b_q     <= run_b_d;
      stall_max_q <= stall_max_d;
    end
  end

  assign wr_cnt_a  = wr_cnt_a_q;
  assign wr_cnt_b  = wr_cnt_b_q;
  assign stall_max = stall_max_q;
`endif

endmodule

// File: tb/tb_io_write_arbiter.sv
// Randomized bench for io_write_arbiter: directed scenarios plus a constrained-random run,
// all checked against a transaction-level model of the arbitration rules.
module tb_io_write_arbiter;
  localparam int MAXB = 4;

  logic io_clk = 1'b0;
  logic resetn = 1'b0;

  io_write_arbiter_if bus();

  io_write_arbiter #(.MAX_BURST(MAXB), .PORT_BASE(6'b100000)) dut (
    .io_clk (io_clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 io_clk = ~io_clk;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h expected=%h", tag, got, exp);
  endtask

  // Model: who currently owns a burst (0 none, 1 A, 2 B), grants used in it, last winner.
  int          m_owner;
  int          m_used;
  bit          m_last_b;
  bit          e_we, e_err, e_gb;
  logic [31:0] e_addr, e_data;
  bit          got_a, got_b;

  function automatic bit legal_addr(input logic [31:0] a);
    int w;
    w = (a >> 2) & 63;
    return (w >= 32) && (w <= 34);
  endfunction

  function automatic logic [31:0] rnd_addr();
    logic [31:0] r;
    logic [5:0]  w;
    r = $urandom();
    if ($urandom_range(0, 2) != 0) w = 6'(32 + $urandom_range(0, 2));
    else                           w = 6'($urandom_range(0, 63));
    return {r[31:8], w, r[1:0]};
  endfunction

  task automatic model_reset();
    m_owner = 0; m_used = 0; m_last_b = 1'b1;
    e_we = 0; e_err = 0; e_gb = 0; e_addr = 0; e_data = 0;
  endtask

  task automatic apply_reset();
    resetn      = 1'b0;
    bus.a_valid = 1'b1; bus.a_lock = 1'b0; bus.a_addr = 32'h80; bus.a_data = 32'h0;
    bus.b_valid = 1'b1; bus.b_lock = 1'b0; bus.b_addr = 32'h84; bus.b_data = 32'h0;
    #1;
    check("rst_a_ready", 32'(bus.a_ready), 0);
    check("rst_b_ready", 32'(bus.b_ready), 0);
    check("rst_we", 32'(bus.write_io_enable), 0);
    check("rst_io_addr", bus.io_addr, 0);
    check("rst_io_datain", bus.io_datain, 0);
    check("rst_grant_b", 32'(bus.grant_b), 0);
    check("rst_addr_err", 32'(bus.addr_err), 0);
    repeat (2) @(posedge io_clk);
    #1;
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    resetn      = 1'b1;
    model_reset();
  endtask

  // One clock: drive requests, check ready against the model, then the registered outputs.
  task automatic step(input bit av, input bit al, input logic [31:0] aa, input logic [31:0] ad,
                      input bit bv, input bit bl, input logic [31:0] ba, input logic [31:0] bd);
    bit ga, gb, free;
    logic [31:0] wa;
    bus.a_valid = av; bus.a_lock = al; bus.a_addr = aa; bus.a_data = ad;
    bus.b_valid = bv; bus.b_lock = bl; bus.b_addr = ba; bus.b_data = bd;
    ga = 0; gb = 0; free = 1;
    if (m_owner == 1 && av && al) begin
      ga = 1; free = 0; m_used++;
      if (m_used >= MAXB) begin m_owner = 0; m_last_b = 0; end
    end else if (m_owner == 2 && bv && bl) begin
      gb = 1; free = 0; m_used++;
      if (m_used >= MAXB) begin m_owner = 0; m_last_b = 1; end
    end
    if (free) begin
      m_owner = 0;
      if (av && bv) begin
        if (m_last_b) ga = 1; else gb = 1;
      end else begin
        ga = av; gb = bv;
      end
      if (ga) begin m_last_b = 0; if (al && MAXB > 1) begin m_owner = 1; m_used = 1; end end
      if (gb) begin m_last_b = 1; if (bl && MAXB > 1) begin m_owner = 2; m_used = 1; end end
    end
    #1;
    check("a_ready", 32'(bus.a_ready), 32'(ga));
    check("b_ready", 32'(bus.b_ready), 32'(gb));
    got_a = bus.a_ready;
    got_b = bus.b_ready;
    if (ga || gb) begin
      wa     = gb ? ba : aa;
      e_addr = wa;
      e_data = gb ? bd : ad;
      e_we   = legal_addr(wa);
      e_err  = !legal_addr(wa);
      e_gb   = gb;
    end else begin
      e_we = 0; e_err = 0;
    end
    @(posedge io_clk);
    #1;
    check("write_io_enable", 32'(bus.write_io_enable), 32'(e_we));
    check("addr_err", 32'(bus.addr_err), 32'(e_err));
    check("io_addr", bus.io_addr, e_addr);
    check("io_datain", bus.io_datain, e_data);
    check("grant_b", 32'(bus.grant_b), 32'(e_gb));
  endtask

  bit          pav, pal, pbv, pbl;
  logic [31:0] paa, pad, pba, pbd;

  initial begin
    apply_reset();

    // Single A write to port 0.
    step(1, 0, 32'h80, 32'h12345678, 0, 0, 32'h0, 32'h0);
    check("t1_a_ready", 32'(got_a), 1);
    check("t1_we", 32'(bus.write_io_enable), 1);
    check("t1_io_addr", bus.io_addr, 32'h80);
    check("t1_io_datain", bus.io_datain, 32'h12345678);
    check("t1_grant_b", 32'(bus.grant_b), 0);

    // Continuous tie without lock alternates starting with A.
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 32'h84, 32'hA000_0000 + i, 1, 0, 32'h88, 32'hB000_0000 + i);
      check("t2_a_ready", 32'(got_a), 32'((i % 2) == 0));
      check("t2_grant_b", 32'(bus.grant_b), 32'((i % 2) == 1));
      check("t2_we", 32'(bus.write_io_enable), 1);
    end

    // B burst lock: four B grants, then A.
    step(1, 0, 32'h80, 32'h1, 0, 0, 32'h0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 32'h80, 32'hAAAA_0000, 1, 1, 32'h88, 32'hBBBB_0000 + i);
      check("t3_b_ready", 32'(got_b), 32'(i < 4));
      check("t3_a_ready", 32'(got_a), 32'(i == 4));
    end

    // Out-of-window write is acknowledged and flagged for one cycle.
    step(1, 0, 32'h90, 32'hDEAD_BEEF, 0, 0, 32'h0, 32'h0);
    check("t4_a_ready", 32'(got_a), 1);
    check("t4_we", 32'(bus.write_io_enable), 0);
    check("t4_err", 32'(bus.addr_err), 1);
    step(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    check("t4_err_clear", 32'(bus.addr_err), 0);

    // B locked twice, then drops valid: A granted in the same cycle.
    step(0, 0, 32'h0, 32'h0, 1, 1, 32'h80, 32'h11);
    step(1, 0, 32'h84, 32'h22, 1, 1, 32'h80, 32'h12);
    check("t5_b_second", 32'(got_b), 1);
    step(1, 0, 32'h84, 32'h22, 0, 0, 32'h0, 32'h0);
    check("t5_a_ready", 32'(got_a), 1);
    check("t5_b_ready", 32'(got_b), 0);

    // Async reset during an A burst kills the strobe without a clock.
    apply_reset();
    step(1, 1, 32'h80, 32'h31, 0, 0, 32'h0, 32'h0);
    step(1, 1, 32'h84, 32'h32, 0, 0, 32'h0, 32'h0);
    check("t6_we_before", 32'(bus.write_io_enable), 1);
    #2 resetn = 1'b0;
    #1;
    check("t6_we_async", 32'(bus.write_io_enable), 0);
    resetn = 1'b1;
    model_reset();
    step(1, 0, 32'h80, 32'h41, 1, 0, 32'h84, 32'h42);
    check("t6_first_tie_a", 32'(got_a), 1);

    // Constrained-random traffic; pending requests stay stable until accepted.
    pav = 0; pbv = 0; got_a = 0; got_b = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!pav || got_a) begin
        pav = ($urandom_range(0, 3) != 0); pal = 1'($urandom_range(0, 1));
        paa = rnd_addr(); pad = $urandom();
      end
      if (!pbv || got_b) begin
        pbv = ($urandom_range(0, 3) != 0); pbl = 1'($urandom_range(0, 1));
        pba = rnd_addr(); pbd = $urandom();
      end
      step(pav, pal, paa, pad, pbv, pbl, pba, pbd);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/io_write_arbiter.md
Name: io_write_arbiter

Overview:
- Shares the single memory-mapped output-port write path (out_port0..2, word addresses 0x80/0x84/0x88, decoded on addr[7:2] = 6'b100000..6'b100010) between two requesters: A (CPU store path) and B (auxiliary master, e.g. debug loader).
- Round-robin arbitration with optional burst lock. Drives the registered write_io_enable/addr/datain triple consumed by the output-port register block on the same clock.

Parameters:
- MAX_BURST, 4, maximum consecutive grants to one locked requester before forced release (1..15).
- PORT_BASE, 6'b100000, addr[7:2] of port 0; legal window is PORT_BASE..PORT_BASE+2.

Ports:
- io_clk  in  1  clock; all state on rising edge
- resetn  in  1  asynchronous active-low reset
- a_valid  in  1  requester A has a write pending
- a_lock  in  1  A requests burst lock (sampled with a_valid)
- a_addr  in  32  A byte address
- a_data  in  32  A write data
- a_ready  out  1  A's write accepted this cycle (combinational)
- b_valid, b_lock, b_addr, b_data, b_ready: same as A, for requester B
- write_io_enable  out  1  registered write strobe to output ports
- io_addr  out  32  registered address
- io_datain  out  32  registered data
- grant_b  out  1  registered; 1 = last issued write came from B
- addr_err  out  1  registered one-cycle pulse: accepted write fell outside the port window

Behaviour:
- Reset (async, resetn=0): write_io_enable=0, io_addr=0, io_datain=0, grant_b=0, addr_err=0, state=IDLE, rr_last=B (so A wins the first tie), burst_cnt=0. a_ready/b_ready=0 while resetn=0.
- Handshake: a transfer occurs when valid && ready in the same cycle. The requester holds addr/data/lock stable until ready. ready never asserts without the matching valid.
- States: IDLE, LOCK_A, LOCK_B.
- IDLE:
  - Only one valid: grant it.
  - Both valid: grant the requester not equal to rr_last.
  - After granting X: rr_last<=X. If X's lock=1 and MAX_BURST>1, go to LOCK_X with burst_cnt<=1.
- LOCK_X:
  - X valid && X lock: grant X, burst_cnt++. The other requester is not granted, even if valid.
  - When burst_cnt reaches MAX_BURST, the grant issued that cycle is the last one; then go to IDLE with rr_last=X, so a waiting other requester wins next.
  - X drops valid or lock: no grant to X. The same cycle is evaluated as IDLE (other requester granted immediately if valid), then state<=IDLE.
- Output stage, cycle after a grant: write_io_enable=1, io_addr/io_datain = winner's addr/data, grant_b = (winner==B). Latency from accept to strobe is exactly 1 cycle. With no grant, write_io_enable=0 and io_addr/io_datain hold their values.
- Legal window: addr[7:2] in PORT_BASE..PORT_BASE+2.
  - Accepted write outside the window: still acknowledged (no deadlock), write_io_enable stays 0, addr_err=1 for one cycle, io_addr/io_datain still updated.
  - Address bits other than [7:2] are ignored for the check.
- Throughput: one write per cycle maximum. Back-to-back grants are allowed; write_io_enable may stay high on consecutive cycles.
- Reset mid-burst: state returns to IDLE and any in-flight output strobe is cancelled immediately (async).
- burst_cnt is 4 bits and saturates; it never wraps.

Optional Feature:
- Macro IO_ARB_STATS_EN.
- Defined: adds outputs wr_cnt_a[15:0] and wr_cnt_b[15:0], reset to 0. Each increments on that requester's accepted legal writes and wraps 0xFFFF->0. Also adds stall_max[7:0]: the longest consecutive valid-but-not-ready run seen on either requester, saturating at 0xFF.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then a_valid=1, a_addr=0x80, a_data=0x12345678 for one cycle -> a_ready=1 in that cycle; next cycle write_io_enable=1, io_addr=0x80, io_datain=0x12345678, grant_b=0.
- a_valid and b_valid held high continuously, no lock -> grants alternate A,B,A,B starting with A; grant_b toggles each cycle; write_io_enable stays 1.
- b_lock=1 with b_valid and a_valid held high, MAX_BURST=4 -> 4 consecutive B grants, then an A grant in cycle 5; during the burst a_ready=0.
- a_valid=1, a_addr=0x90 -> a_ready=1; next cycle write_io_enable=0 and addr_err=1 for exactly one cycle.
- B locked and granted twice, then b_valid drops while a_valid=1 -> A granted in that same cycle; state returns to IDLE.
- resetn pulsed low while write_io_enable=1 in LOCK_A -> write_io_enable=0 immediately without a clock; after release, the first tie goes to A.
